irq_nest_ctrl: RTL and testbench

- Three-level nested interrupt controller that sequences the PC/backup datapath.
- Latches edge-triggered requests, masks them, and arbitrates by fixed priority. Only a strictly higher level may preempt the active one.
- Issues one-cycle take pulses carrying the vector and save slot, and one-cycle restore pulses carrying the restore slot, to the PC unit.
- Sits between external interrupt lines, the instruction decoder (eret) and the PC/backup logic.

---
 rtl/irq_nest_ctrl_if.sv | 30 +++
 rtl/irq_nest_ctrl.sv | 144 ++++++++++++++
 tb/tb_irq_nest_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_nest_ctrl_if.sv
// Bus between the nested interrupt controller and its surroundings:
// request lines, decoder eret, PC-unit handshake and status outputs.
interface irq_nest_ctrl_if;
  logic [2:0]  irq_in;
  logic [2:0]  irq_mask;
  logic        int_enable;
  logic        pc_ready;
  logic        eret;
  logic        take;
  logic [31:0] vector;
  logic [1:0]  save_slot;
  logic        restore;
  logic [1:0]  restore_slot;
  logic [2:0]  in_service;
  logic [2:0]  pending;
  logic [1:0]  depth;
  logic        err_spurious;

  modport master (
    output irq_in, irq_mask, int_enable, pc_ready, eret,
    input  take, vector, save_slot, restore, restore_slot,
           in_service, pending, depth, err_spurious
  );

  modport slave (
    input  irq_in, irq_mask, int_enable, pc_ready, eret,
    output take, vector, save_slot, restore, restore_slot,
           in_service, pending, depth, err_spurious
  );
endinterface

// File: rtl/irq_nest_ctrl.sv
// Three-level nested interrupt controller: edge capture, masking, strict
// priority preemption and take/restore sequencing of the PC backup slots.
module irq_nest_ctrl #(
  parameter logic [31:0] VEC_BASE    = 32'h0000_0038,
  parameter logic [31:0] VEC_STRIDE  = 32'h0000_0038,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input logic           clk,
  input logic           clr,
  irq_nest_ctrl_if.slave bus
);

  localparam int unsigned LVL    = 3;
  localparam int unsigned SLOT_W = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned VEC_W  = 32;

  typedef enum logic [1:0] {IDLE, TAKE, RET, HOLD} state_t;

  state_t              state_q, state_d;
  logic [LVL-1:0]      irq_q, pending_q, pending_d, in_service_q, in_service_d;
  logic [SLOT_W-1:0]   depth_q, depth_d, save_slot_q, save_slot_d;
  logic [SLOT_W-1:0]   restore_slot_q, restore_slot_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [VEC_W-1:0]    vector_q, vector_d;
  logic                eret_pend_q, eret_pend_d, take_q, take_d;
  logic                restore_q, restore_d, err_q, err_d;

  logic [LVL-1:0]      edges, elig, top_mask, win_mask;
  logic [SLOT_W-1:0]   cur, winner;

  // Current service level (top in_service bit + 1) and the eligible winner
  always_comb begin
    edges = bus.irq_in & ~irq_q;
    if (in_service_q[2]) begin
      cur = 2'd3; top_mask = 3'b100;
    end else if (in_service_q[1]) begin
      cur = 2'd2; top_mask = 3'b010;
    end else if (in_service_q[0]) begin
      cur = 2'd1; top_mask = 3'b001;
    end else begin
      cur = 2'd0; top_mask = 3'b000;
    end
    elig[0] = pending_q[0] & ~bus.irq_mask[0] & (cur == 2'd0);
    elig[1] = pending_q[1] & ~bus.irq_mask[1] & (cur <= 2'd1);
    elig[2] = pending_q[2] & ~bus.irq_mask[2] & (cur <= 2'd2);
    winner   = elig[2] ? 2'd2 : (elig[1] ? 2'd1 : 2'd0);
    win_mask = LVL'(1) << winner;
  end

  // Next-state and next-output logic; pulses default low, everything else holds
  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q | edges;
    in_service_d   = in_service_q;
    depth_d        = depth_q;
    eret_pend_d    = eret_pend_q;
    cnt_d          = cnt_q;
    take_d         = 1'b0;
    restore_d      = 1'b0;
    vector_d       = vector_q;
    save_slot_d    = save_slot_q;
    restore_slot_d = restore_slot_q;
    err_d          = err_q;
    case (state_q)
      IDLE: begin
        if (bus.eret || eret_pend_q) begin
          eret_pend_d = 1'b0;
          if (depth_q == 2'd0) begin
            err_d = 1'b1;
          end else begin
            restore_d      = 1'b1;
            restore_slot_d = depth_q - 2'd1;
            in_service_d   = in_service_q & ~top_mask;
            depth_d        = depth_q - 2'd1;
            state_d        = RET;
          end
        end else if (bus.int_enable && bus.pc_ready && (|elig)) begin
          take_d       = 1'b1;
          vector_d     = VEC_BASE + VEC_W'(winner) * VEC_STRIDE;
          save_slot_d  = depth_q;
          in_service_d = in_service_q | win_mask;
          pending_d    = pending_d & ~win_mask;
          depth_d      = depth_q + 2'd1;
          state_d      = TAKE;
        end
      end
      TAKE, RET: begin
        if (bus.eret) eret_pend_d = 1'b1;
        cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.eret) eret_pend_d = 1'b1;
        if (cnt_q == CNT_W'(0)) state_d = IDLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q        <= IDLE;
      irq_q          <= '0;
      pending_q      <= '0;
      in_service_q   <= '0;
      depth_q        <= '0;
      eret_pend_q    <= 1'b0;
      cnt_q          <= '0;
      take_q         <= 1'b0;
      restore_q      <= 1'b0;
      vector_q       <= '0;
      save_slot_q    <= '0;
      restore_slot_q <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      irq_q          <= bus.irq_in;
      pending_q      <= pending_d;
      in_service_q   <= in_service_d;
      depth_q        <= depth_d;
      eret_pend_q    <= eret_pend_d;
      cnt_q          <= cnt_d;
      take_q         <= take_d;
      restore_q      <= restore_d;
      vector_q       <= vector_d;
      save_slot_q    <= save_slot_d;
      restore_slot_q <= restore_slot_d;
      err_q          <= err_d;
    end
  end

  assign bus.take         = take_q;
  assign bus.vector       = vector_q;
  assign bus.save_slot    = save_slot_q;
  assign bus.restore      = restore_q;
  assign bus.restore_slot = restore_slot_q;
  assign bus.in_service   = in_service_q;
  assign bus.pending      = pending_q;
  assign bus.depth        = depth_q;
  assign bus.err_spurious = err_q;

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// Directed bench for irq_nest_ctrl: take/restore events are predicted into a
// scoreboard queue as stimulus is applied and matched when the pulses appear.
module tb_irq_nest_ctrl;

  typedef struct {
    bit          is_take;
    logic [31:0] vec;
    logic [1:0]  slot;
  } ev_t;

  bit clk = 1'b0;
  logic clr;
  irq_nest_ctrl_if bus();

  ev_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  gap;

  irq_nest_ctrl #(
    .VEC_BASE   (32'h0000_0038),
    .VEC_STRIDE (32'h0000_0038),
    .HOLD_CYCLES(2)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_take(input logic [31:0] vec, input logic [1:0] slot);
    ev_t e;
    e.is_take = 1'b1; e.vec = vec; e.slot = slot;
    sb.push_back(e);
  endtask

  task automatic push_restore(input logic [1:0] slot);
    ev_t e;
    e.is_take = 1'b0; e.vec = '0; e.slot = slot;
    sb.push_back(e);
  endtask

  // Tick until the chosen pulse is seen; one-cycle inputs are dropped after the first edge
  task automatic wait_pulse(input bit is_take, input int budget, input string tag, output int n);
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      tick();
      bus.irq_in = 3'b000;
      bus.eret   = 1'b0;
      n++;
      seen = is_take ? bus.take : bus.restore;
    end
    chk(tag, 32'(seen), 32'h1);
  endtask

  // Scoreboard monitor: every take/restore pulse must match the oldest prediction
  always @(posedge clk) begin
    #1;
    if (bus.take || bus.restore) begin
      ev_t e;
      chk("take_and_restore_exclusive", 32'(bus.take & bus.restore), 32'h0);
      vectors++;
      assert (sb.size() > 0) else begin
        miscompares++;
        $error("FAIL sb_unexpected observed take=%0b restore=%0b expected no event",
               bus.take, bus.restore);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_kind", 32'(bus.take), 32'(e.is_take));
        if (e.is_take) begin
          chk("sb_vector", bus.vector, e.vec);
          chk("sb_save_slot", 32'(bus.save_slot), 32'(e.slot));
        end else begin
          chk("sb_restore_slot", 32'(bus.restore_slot), 32'(e.slot));
        end
      end
    end
  end

  initial begin
    clr            = 1'b1;
    bus.irq_in     = 3'b000;
    bus.irq_mask   = 3'b000;
    bus.int_enable = 1'b1;
    bus.pc_ready   = 1'b1;
    bus.eret       = 1'b0;
    tick(2);
    chk("rst_take", 32'(bus.take), 32'h0);
    chk("rst_vector", bus.vector, 32'h0);
    chk("rst_pending", 32'(bus.pending), 32'h0);
    chk("rst_depth", 32'(bus.depth), 32'h0);
    clr = 1'b0;

    // Basic entry: edge latched one edge later, take on the following edge
    bus.irq_in = 3'b001;
    tick();
    bus.irq_in = 3'b000;
    chk("basic_pending", 32'(bus.pending), 32'h1);
    chk("basic_no_early_take", 32'(bus.take), 32'h0);
    push_take(32'h38, 2'd0);
    tick();
    chk("basic_take", 32'(bus.take), 32'h1);
    chk("basic_in_service", 32'(bus.in_service), 32'h1);
    chk("basic_depth", 32'(bus.depth), 32'h1);
    chk("basic_pending_clr", 32'(bus.pending), 32'h0);
    tick(3);
    bus.eret = 1'b1;
    push_restore(2'd0);
    tick();
    bus.eret = 1'b0;
    chk("basic_restore", 32'(bus.restore), 32'h1);
    chk("basic_depth0", 32'(bus.depth), 32'h0);
    // HOLD spans exactly two cycles after the restore
    bus.irq_in = 3'b001;
    push_take(32'h38, 2'd0);
    wait_pulse(1'b1, 10, "hold_take_seen", gap);
    chk("hold_gap", 32'(gap), 32'h4);

    // Nesting: irq0 in service, irq2 preempts
    bus.irq_in = 3'b100;
    push_take(32'hA8, 2'd1);
    wait_pulse(1'b1, 12, "nest_take_seen", gap);
    chk("nest_in_service", 32'(bus.in_service), 32'h5);
    chk("nest_depth", 32'(bus.depth), 32'h2);
    bus.eret = 1'b1;
    push_restore(2'd1);
    wait_pulse(1'b0, 12, "nest_restore1_seen", gap);
    chk("nest_in_service_after1", 32'(bus.in_service), 32'h1);
    bus.eret = 1'b1;
    push_restore(2'd0);
    wait_pulse(1'b0, 12, "nest_restore0_seen", gap);
    chk("nest_in_service_after0", 32'(bus.in_service), 32'h0);
    tick(4);

    // No lower-level preemption
    bus.irq_in = 3'b100;
    push_take(32'hA8, 2'd0);
    wait_pulse(1'b1, 10, "nolow_take2_seen", gap);
    bus.irq_in = 3'b010;
    tick();
    bus.irq_in = 3'b000;
    tick(5);
    chk("nolow_pending", 32'(bus.pending), 32'h2);
    chk("nolow_in_service", 32'(bus.in_service), 32'h4);
    bus.eret = 1'b1;
    push_restore(2'd0);
    wait_pulse(1'b0, 10, "nolow_restore_seen", gap);
    push_take(32'h70, 2'd0);
    wait_pulse(1'b1, 10, "nolow_take1_seen", gap);
    chk("nolow_gap", 32'(gap), 32'h4);
    bus.eret = 1'b1;
    push_restore(2'd0);
    wait_pulse(1'b0, 10, "nolow_restore2_seen", gap);
    tick(4);

    // Simultaneous edges: highest wins, lower waits for the return
    bus.irq_in = 3'b101;
    push_take(32'hA8, 2'd0);
    wait_pulse(1'b1, 10, "simul_take2_seen", gap);
    tick(5);
    chk("simul_pending", 32'(bus.pending), 32'h1);
    chk("simul_in_service", 32'(bus.in_service), 32'h4);
    bus.eret = 1'b1;
    push_restore(2'd0);
    wait_pulse(1'b0, 10, "simul_restore_seen", gap);
    push_take(32'h38, 2'd0);
    wait_pulse(1'b1, 10, "simul_take0_seen", gap);
    chk("simul_gap", 32'(gap), 32'h4);
    bus.eret = 1'b1;
    push_restore(2'd0);
    wait_pulse(1'b0, 10, "simul_restore2_seen", gap);
    tick(4);

    // Masking keeps pending; pc_ready gates the take to the exact edge
    bus.irq_mask = 3'b001;
    bus.irq_in = 3'b001;
    tick();
    bus.irq_in = 3'b000;
    tick(4);
    chk("mask_pending", 32'(bus.pending), 32'h1);
    chk("mask_in_service", 32'(bus.in_service), 32'h0);
    bus.pc_ready = 1'b0;
    bus.irq_mask = 3'b000;
    tick(3);
    chk("ready_pending", 32'(bus.pending), 32'h1);
    bus.pc_ready = 1'b1;
    push_take(32'h38, 2'd0);
    tick();
    chk("ready_take_exact", 32'(bus.take), 32'h1);
    bus.eret = 1'b1;
    push_restore(2'd0);
    wait_pulse(1'b0, 10, "ready_restore_seen", gap);
    tick(4);

    // Spurious eret at depth 0
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    chk("spur_err", 32'(bus.err_spurious), 32'h1);
    chk("spur_no_restore", 32'(bus.restore), 32'h0);
    tick();
    chk("spur_sticky", 32'(bus.err_spurious), 32'h1);

    // Global enable blocks takes without dropping pending
    bus.int_enable = 1'b0;
    bus.irq_in = 3'b010;
    tick();
    bus.irq_in = 3'b000;
    tick(3);
    chk("gate_pending", 32'(bus.pending), 32'h2);
    bus.int_enable = 1'b1;
    push_take(32'h70, 2'd0);
    wait_pulse(1'b1, 5, "gate_take_seen", gap);
    bus.eret = 1'b1;
    push_restore(2'd0);
    wait_pulse(1'b0, 10, "gate_restore_seen", gap);
    tick(4);

    // Reset in HOLD with two levels active, request held across release
    bus.irq_in = 3'b001;
    push_take(32'h38, 2'd0);
    wait_pulse(1'b1, 10, "rmid_take0_seen", gap);
    bus.irq_in = 3'b010;
    push_take(32'h70, 2'd1);
    wait_pulse(1'b1, 12, "rmid_take1_seen", gap);
    tick();
    chk("rmid_in_service", 32'(bus.in_service), 32'h3);
    #2;
    clr = 1'b1;
    bus.irq_in = 3'b100;
    #1;
    chk("rmid_async_in_service", 32'(bus.in_service), 32'h0);
    chk("rmid_async_depth", 32'(bus.depth), 32'h0);
    chk("rmid_async_vector", bus.vector, 32'h0);
    chk("rmid_async_save_slot", 32'(bus.save_slot), 32'h0);
    chk("rmid_async_err", 32'(bus.err_spurious), 32'h0);
    tick(2);
    clr = 1'b0;
    push_take(32'hA8, 2'd0);
    tick();
    chk("rel_pending", 32'(bus.pending), 32'h4);
    chk("rel_no_take", 32'(bus.take), 32'h0);
    tick();
    chk("rel_take", 32'(bus.take), 32'h1);
    chk("rel_in_service", 32'(bus.in_service), 32'h4);
    bus.irq_in = 3'b000;
    tick(4);
    chk("sb_drain", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
